// File: rtl/multi_ch_fifo.sv
//------------------------------------------------------------------------------
// Module      : multi_ch_fifo
// Description : CH_NUM independent synchronous FIFOs sharing one write port and
//               one read port, with per-channel status and error pulses.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multi_ch_fifo #(
  parameter  int CH_NUM     = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int ADDR_WIDTH = 4,
  parameter  int AFULL_TH   = 14,
  parameter  int AEMPTY_TH  = 2,
  localparam int c_CHW      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               wr_en,
  input  logic [c_CHW-1:0]                   wr_ch,
  input  logic [DATA_WIDTH-1:0]              din,
  input  logic                               rd_en,
  input  logic [c_CHW-1:0]                   rd_ch,
  output logic [DATA_WIDTH-1:0]              dout,
  output logic                               dout_valid,
  output logic [c_CHW-1:0]                   dout_ch,
  output logic [CH_NUM-1:0]                  full,
  output logic [CH_NUM-1:0]                  empty,
  output logic [CH_NUM-1:0]                  almost_full,
  output logic [CH_NUM-1:0]                  almost_empty,
  output logic [CH_NUM*(ADDR_WIDTH+1)-1:0]   data_count,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int c_DEPTH = 2**ADDR_WIDTH;
  localparam int c_CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] r_mem   [CH_NUM*c_DEPTH];
  logic [ADDR_WIDTH-1:0] r_wptr  [CH_NUM];
  logic [ADDR_WIDTH-1:0] r_rptr  [CH_NUM];
  logic [c_CW-1:0]       r_count [CH_NUM];

  logic                  w_wr_in_range;
  logic                  w_rd_in_range;
  logic                  w_wr_accept;
  logic                  w_rd_accept;
  logic [ADDR_WIDTH-1:0] w_wr_ptr;
  logic [ADDR_WIDTH-1:0] w_rd_ptr;
  logic [CH_NUM-1:0]     w_wr_sel;
  logic [CH_NUM-1:0]     w_rd_sel;

  assign w_wr_in_range = (32'(wr_ch) < CH_NUM);
  assign w_rd_in_range = (32'(rd_ch) < CH_NUM);

  // Acceptance uses the pre-edge flags, so a full channel refuses a write even
  // while it is being read, and an empty one refuses a read while being written.
  assign w_wr_accept = wr_en && w_wr_in_range && !full[wr_ch];
  assign w_rd_accept = rd_en && w_rd_in_range && !empty[rd_ch];

  assign w_wr_ptr = w_wr_in_range ? r_wptr[wr_ch] : '0;
  assign w_rd_ptr = w_rd_in_range ? r_rptr[rd_ch] : '0;

  generate
    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
      assign w_wr_sel[i]     = w_wr_accept && (32'(wr_ch) == i);
      assign w_rd_sel[i]     = w_rd_accept && (32'(rd_ch) == i);
      assign full[i]         = (r_count[i] == c_CW'(c_DEPTH));
      assign empty[i]        = (r_count[i] == '0);
      assign almost_full[i]  = (r_count[i] >= c_CW'(AFULL_TH));
      assign almost_empty[i] = (r_count[i] <= c_CW'(AEMPTY_TH));
      assign data_count[i*c_CW +: c_CW] = r_count[i];
    end
  endgenerate

  // Storage is deliberately left out of reset; channel i owns the slice at i*DEPTH.
  always_ff @(posedge clk) begin
    if (w_wr_accept) begin
      r_mem[{wr_ch, w_wr_ptr}] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (w_wr_sel[i]) begin
          r_wptr[i] <= r_wptr[i] + ADDR_WIDTH'(1);
        end
        if (w_rd_sel[i]) begin
          r_rptr[i] <= r_rptr[i] + ADDR_WIDTH'(1);
        end
        if (w_wr_sel[i] && !w_rd_sel[i]) begin
          r_count[i] <= r_count[i] + c_CW'(1);
        end else if (!w_wr_sel[i] && w_rd_sel[i]) begin
          r_count[i] <= r_count[i] - c_CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_ch    <= '0;
      dout_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      dout_valid <= w_rd_accept;
      overflow   <= wr_en && !w_wr_accept;
      underflow  <= rd_en && !w_rd_accept;
      if (w_rd_accept) begin
        dout    <= r_mem[{rd_ch, w_rd_ptr}];
        dout_ch <= rd_ch;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_multi_ch_fifo.sv
//------------------------------------------------------------------------------
// Module      : tb_multi_ch_fifo
// Description : Self-checking bench for multi_ch_fifo against a queue-based model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_multi_ch_fifo;

  localparam int CH    = 4;
  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = AW + 1;
  localparam logic [35:0] RESET_STATUS = {4'h0, 4'hF, 4'h0, 4'hF, 20'h0};

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [1:0]        wr_ch;
  logic [DW-1:0]     din;
  logic              rd_en;
  logic [1:0]        rd_ch;
  logic [DW-1:0]     dout;
  logic              dout_valid;
  logic [1:0]        dout_ch;
  logic [CH-1:0]     full, empty, almost_full, almost_empty;
  logic [CH*CW-1:0]  data_count;
  logic              overflow, underflow;
  logic [35:0]       act_status;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] q [CH][$];
  logic [DW-1:0] exp_dout;
  logic [1:0]    exp_dout_ch;
  logic          exp_valid, exp_ovf, exp_unf;

  always #5 clk = ~clk;

  assign act_status = {full, empty, almost_full, almost_empty, data_count};

  multi_ch_fifo #(
    .CH_NUM(CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_TH(14), .AEMPTY_TH(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_ch(wr_ch), .din(din),
    .rd_en(rd_en), .rd_ch(rd_ch),
    .dout(dout), .dout_valid(dout_valid), .dout_ch(dout_ch),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .data_count(data_count), .overflow(overflow), .underflow(underflow)
  );

  // Expected flags derived directly from each channel's queue occupancy.
  function automatic logic [35:0] exp_status();
    logic [3:0]  f, e, af, ae;
    logic [19:0] dc;
    f = '0; e = '0; af = '0; ae = '0; dc = '0;
    for (int ch = 0; ch < CH; ch++) begin
      int n;
      n = q[ch].size();
      f[ch]  = (n == DEPTH);
      e[ch]  = (n == 0);
      af[ch] = (n >= 14);
      ae[ch] = (n <= 2);
      dc[ch*CW +: CW] = CW'(n);
    end
    return {f, e, af, ae, dc};
  endfunction

  task automatic model_clear();
    for (int ch = 0; ch < CH; ch++) q[ch].delete();
    exp_dout = '0; exp_dout_ch = '0; exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
  endtask

  // Drives one cycle of stimulus and advances the model; outputs sampled at +1.
  task automatic do_cycle(input logic we, input logic [1:0] wc, input logic [7:0] d,
                          input logic re, input logic [1:0] rc);
    logic wr_ok, rd_ok;
    @(negedge clk);
    wr_en = we; wr_ch = wc; din = d; rd_en = re; rd_ch = rc;
    wr_ok = we && (q[wc].size() < DEPTH);
    rd_ok = re && (q[rc].size() > 0);
    exp_valid = rd_ok;
    exp_ovf   = we && !wr_ok;
    exp_unf   = re && !rd_ok;
    if (rd_ok) begin
      exp_dout    = q[rc].pop_front();
      exp_dout_ch = rc;
    end
    if (wr_ok) q[wc].push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_ch = '0; rd_ch = '0; din = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (act_status !== RESET_STATUS)
      $display("FAIL reset_status: got %h expected %h", act_status, RESET_STATUS);
    if (act_status !== RESET_STATUS) errors++;
    checks++;
    if ({dout_valid, overflow, underflow, dout, dout_ch} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b ov=%b un=%b dout=%h ch=%0d expected all zero",
               dout_valid, overflow, underflow, dout, dout_ch);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_fill_ch2();
    for (int i = 0; i < 17; i++) begin
      do_cycle(1'b1, 2'd2, 8'(i), 1'b0, 2'd0);
      checks++;
      if (overflow !== exp_ovf) begin
        errors++;
        $display("FAIL fill_overflow[%0d]: got %b expected %b", i, overflow, exp_ovf);
      end
      checks++;
      if (act_status !== exp_status()) begin
        errors++;
        $display("FAIL fill_status[%0d]: got %h expected %h", i, act_status, exp_status());
      end
      if (i == 12 || i == 13) begin
        checks++;
        if (almost_full[2] !== (i == 13)) begin
          errors++;
          $display("FAIL fill_afull[%0d]: got %b expected %b", i, almost_full[2], (i == 13));
        end
      end
    end
    checks++;
    if (full[2] !== 1'b1 || data_count[2*CW +: CW] !== 5'd16 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL fill_final: got full=%b count=%0d ov=%b expected 1 16 1",
               full[2], data_count[2*CW +: CW], overflow);
    end
    do_cycle(1'b0, 2'd0, 8'h00, 1'b0, 2'd0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL fill_ov_pulse: got %b expected 0", overflow);
    end
  endtask

  task automatic test_drain_ch2();
    for (int i = 0; i < 17; i++) begin
      do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd2);
      checks++;
      if (dout_valid !== exp_valid || dout !== exp_dout || dout_ch !== exp_dout_ch) begin
        errors++;
        $display("FAIL drain_data[%0d]: got v=%b d=%h ch=%0d expected v=%b d=%h ch=%0d",
                 i, dout_valid, dout, dout_ch, exp_valid, exp_dout, exp_dout_ch);
      end
      checks++;
      if (underflow !== exp_unf || act_status !== exp_status()) begin
        errors++;
        $display("FAIL drain_status[%0d]: got un=%b st=%h expected un=%b st=%h",
                 i, underflow, act_status, exp_unf, exp_status());
      end
    end
    checks++;
    if (empty[2] !== 1'b1 || underflow !== 1'b1) begin
      errors++;
      $display("FAIL drain_final: got empty=%b un=%b expected 1 1", empty[2], underflow);
    end
  endtask

  task automatic test_interleave();
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) do_cycle(1'b1, 2'd0, 8'hA0 + 8'(i / 2), 1'b0, 2'd0);
      else            do_cycle(1'b1, 2'd3, 8'hB0 + 8'(i / 2), 1'b0, 2'd0);
    end
    for (int i = 0; i < 16; i++) begin
      do_cycle(1'b0, 2'd0, 8'h00, 1'b1, (i < 8) ? 2'd3 : 2'd0);
      checks++;
      if (dout_valid !== exp_valid || dout !== exp_dout || dout_ch !== exp_dout_ch) begin
        errors++;
        $display("FAIL interleave_data[%0d]: got v=%b d=%h ch=%0d expected v=%b d=%h ch=%0d",
                 i, dout_valid, dout, dout_ch, exp_valid, exp_dout, exp_dout_ch);
      end
      checks++;
      if (act_status !== exp_status() || empty[2:1] !== 2'b11) begin
        errors++;
        $display("FAIL interleave_status[%0d]: got %h expected %h", i, act_status, exp_status());
      end
    end
  endtask

  task automatic test_same_cycle();
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 2'd1, 8'($urandom), 1'b0, 2'd0);
    do_cycle(1'b1, 2'd1, 8'h5A, 1'b1, 2'd1);
    checks++;
    if (dout_valid !== 1'b1 || overflow !== 1'b1 || underflow !== 1'b0 ||
        data_count[CW +: CW] !== 5'd15 || dout !== exp_dout) begin
      errors++;
      $display("FAIL same_full: got v=%b ov=%b un=%b cnt=%0d d=%h expected 1 1 0 15 %h",
               dout_valid, overflow, underflow, data_count[CW +: CW], dout, exp_dout);
    end
    for (int i = 0; i < 15; i++) begin
      do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
      checks++;
      if (dout_valid !== exp_valid || dout !== exp_dout) begin
        errors++;
        $display("FAIL same_drain[%0d]: got v=%b d=%h expected v=%b d=%h",
                 i, dout_valid, dout, exp_valid, exp_dout);
      end
    end
    do_cycle(1'b1, 2'd1, 8'hC3, 1'b1, 2'd1);
    checks++;
    if (dout_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b1 ||
        data_count[CW +: CW] !== 5'd1) begin
      errors++;
      $display("FAIL same_empty: got v=%b ov=%b un=%b cnt=%0d expected 0 0 1 1",
               dout_valid, overflow, underflow, data_count[CW +: CW]);
    end
    do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd1);
    checks++;
    if (dout_valid !== 1'b1 || dout !== 8'hC3 || act_status !== exp_status()) begin
      errors++;
      $display("FAIL same_readback: got v=%b d=%h expected 1 c3", dout_valid, dout);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 2'd0, 8'($urandom), 1'b0, 2'd0);
    @(negedge clk);
    wr_en = 1'b1; wr_ch = 2'd0; din = 8'hEE; rst_n = 1'b0;
    #1;
    checks++;
    if (act_status !== RESET_STATUS || {dout_valid, overflow, underflow, dout} !== '0) begin
      errors++;
      $display("FAIL midreset_async: got %h expected %h", act_status, RESET_STATUS);
    end
    @(negedge clk);
    rst_n = 1'b1; wr_en = 1'b0;
    model_clear();
    do_cycle(1'b0, 2'd0, 8'h00, 1'b1, 2'd0);
    checks++;
    if (underflow !== 1'b1 || dout_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_underflow: got un=%b v=%b expected 1 0", underflow, dout_valid);
    end
    for (int k = 0; k < 21; k++) begin
      do_cycle(k < 20, 2'd0, 8'($urandom), k > 0, 2'd0);
      checks++;
      if (dout_valid !== exp_valid || dout !== exp_dout || act_status !== exp_status()) begin
        errors++;
        $display("FAIL wrap[%0d]: got v=%b d=%h st=%h expected v=%b d=%h st=%h",
                 k, dout_valid, dout, act_status, exp_valid, exp_dout, exp_status());
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      do_cycle($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom),
               $urandom_range(0, 1) != 0, 2'($urandom));
      checks++;
      if (dout_valid !== exp_valid || dout !== exp_dout || dout_ch !== exp_dout_ch) begin
        errors++;
        $display("FAIL random_data[%0d]: got v=%b d=%h ch=%0d expected v=%b d=%h ch=%0d",
                 i, dout_valid, dout, dout_ch, exp_valid, exp_dout, exp_dout_ch);
      end
      checks++;
      if (overflow !== exp_ovf || underflow !== exp_unf || act_status !== exp_status()) begin
        errors++;
        $display("FAIL random_status[%0d]: got ov=%b un=%b st=%h expected ov=%b un=%b st=%h",
                 i, overflow, underflow, act_status, exp_ovf, exp_unf, exp_status());
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_clear();
    test_reset();
    test_fill_ch2();
    test_drain_ch2();
    test_interleave();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/multi_ch_fifo.md
MULTI_CH_FIFO -- requirements
Module: multi_ch_fifo

Interface
REQ-001 The block SHALL have parameter CH_NUM, default 4, number of independent FIFO channels (legal 2..16).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, width of din and dout in bits.
REQ-003 The block SHALL have parameter ADDR_WIDTH, default 4, giving per-channel depth DEPTH = 2**ADDR_WIDTH.
REQ-004 The block SHALL have parameter AFULL_TH, default 14, almost-full threshold (legal 1..DEPTH-1).
REQ-005 The block SHALL have parameter AEMPTY_TH, default 2, almost-empty threshold (legal 1..DEPTH-1).
REQ-006 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clk  in  1  sole clock; all state changes on its rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 wr_en  in  1  write request.
REQ-010 wr_ch  in  CHW  write channel select, CHW = max(1, clog2(CH_NUM)).
REQ-011 din  in  DATA_WIDTH  write data.
REQ-012 rd_en  in  1  read request.
REQ-013 rd_ch  in  CHW  read channel select.
REQ-014 dout  out  DATA_WIDTH  read data, registered.
REQ-015 dout_valid  out  1  one-cycle pulse qualifying dout.
REQ-016 dout_ch  out  CHW  channel that produced dout.
REQ-017 full, empty, almost_full, almost_empty  out  CH_NUM each  per-channel status, bit i = channel i.
REQ-018 data_count  out  CH_NUM*(ADDR_WIDTH+1)  per-channel occupancy, channel i in bits [i*(ADDR_WIDTH+1) +: ADDR_WIDTH+1].
REQ-019 overflow, underflow  out  1 each  one-cycle error pulses.

Function
REQ-020 Each channel SHALL hold its own storage, write pointer, read pointer (ADDR_WIDTH bits, wrapping DEPTH-1 -> 0) and count (0..DEPTH).
REQ-021 A write SHALL be accepted when wr_en=1, wr_ch<CH_NUM and full[wr_ch]=0; din stored at that channel's write pointer, pointer +1.
REQ-022 A read SHALL be accepted when rd_en=1, rd_ch<CH_NUM and empty[rd_ch]=0; read pointer +1.
REQ-023 Read latency SHALL be 1 cycle: dout, dout_ch and dout_valid=1 appear the cycle after acceptance; otherwise dout and dout_ch hold, dout_valid=0.
REQ-024 Flags SHALL be decoded from registered counts: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AFULL_TH), almost_empty=(count<=AEMPTY_TH); they change the cycle after the accepting edge.
REQ-025 Full/empty SHALL be evaluated pre-edge: write to a full channel is rejected even with a concurrent read of it; read of an empty channel is rejected even with a concurrent write to it.
REQ-026 Accepted write and read to the same channel in one cycle SHALL leave its count unchanged and move both pointers.
REQ-027 Operations on different channels SHALL be fully independent in the same cycle.
REQ-028 overflow SHALL pulse 1 the cycle after a rejected write (full or out-of-range channel); underflow likewise for a rejected read; neither alters state.
REQ-029 Data SHALL leave each channel in write order; no cross-channel reordering affects per-channel order.

Reset
REQ-030 rst_n=0 SHALL immediately clear all pointers and counts, dout=0, dout_ch=0, dout_valid=0, overflow=0, underflow=0, empty and almost_empty all 1, full and almost_full all 0; storage contents are not reset.
REQ-031 Reset asserted mid-operation SHALL discard all queued data; the first post-reset read of any channel is rejected as underflow.
REQ-032 rst_n release is synchronised to clk externally; the block accepts operations from the first edge with rst_n=1.

Verification (defaults CH_NUM=4, DATA_WIDTH=8, ADDR_WIDTH=4)
REQ-033 Reset -> empty=4'b1111, almost_empty=4'b1111, full=0, data_count all 0, dout_valid=0.
REQ-034 Write 16 bytes 0x00..0x0F to ch2, then one more -> full[2]=1, almost_full[2] set when count reaches 14, 17th write gives overflow pulse, count stays 16.
REQ-035 Read ch2 16 times -> dout 0x00..0x0F, dout_ch=2, one cycle after each rd_en; 17th read gives underflow pulse, empty[2]=1.
REQ-036 Interleave writes to ch0 (0xA0..) and ch3 (0xB0..) every cycle, then read ch3 then ch0 -> each channel returns its own sequence in order; ch1, ch2 stay empty.
REQ-037 ch1 holding 16 entries, rd_en and wr_en on ch1 same cycle -> read accepted, write rejected with overflow, count 15; with ch1 empty both set -> write accepted, read underflow, count 1.
REQ-038 Fill ch0 to 8, assert rst_n=0 mid-burst for 1 cycle -> all flags return to reset values asynchronously; subsequent 20 write/read cycles across the pointer wrap return correct data.
